// File: rtl/integer_divide.sv
// rtl/integer_divide.sv - multi-cycle restoring integer divider with result backpressure
// Optional signed support: define INTEGER_DIVIDE_SIGNED_EN.
module integer_divide #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_ack,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero,
    output logic             o_overflow
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] quo, dvs, quo_nxt, quo_fix, rem_fix;
    logic [WIDTH:0]   rem, rem_nxt;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             div_zero;

`ifdef INTEGER_DIVIDE_SIGNED_EN
    logic dvd_neg, dvs_neg, q_neg, r_neg, ovf_case, res_ovf;

    assign dvd_neg = i_signed & i_dividend[WIDTH-1];
    assign dvs_neg = i_signed & i_divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    assign dvs_mag = dvs_neg ? -i_divisor : i_divisor;
    assign quo_fix = q_neg ? -quo : quo;
    // With a zero divisor the partial remainder ends as |dividend|, so re-signing restores the dividend.
    assign rem_fix = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    assign o_overflow = res_ovf;
`else
    logic unused_signed;

    assign unused_signed = i_signed;
    assign dvd_mag = i_dividend;
    assign dvs_mag = i_divisor;
    assign quo_fix = quo;
    assign rem_fix = rem[WIDTH-1:0];
    assign o_overflow = 1'b0;
`endif

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    always_comb begin
        rem_nxt = rem;
        quo_nxt = quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_nxt = {rem_nxt[WIDTH-1:0], quo_nxt[WIDTH-1]};
            quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
            if (rem_nxt >= {1'b0, dvs}) begin
                rem_nxt    = rem_nxt - {1'b0, dvs};
                quo_nxt[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (step_cnt == CNT_W'(STEPS - 1)) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_DONE;
            S_DONE:  if (i_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_cnt      <= '0;
            quo           <= '0;
            dvs           <= '0;
            rem           <= '0;
            div_zero      <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
`ifdef INTEGER_DIVIDE_SIGNED_EN
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            ovf_case      <= 1'b0;
            res_ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    quo      <= dvd_mag;
                    dvs      <= dvs_mag;
                    rem      <= '0;
                    step_cnt <= '0;
                    div_zero <= (i_divisor == '0);
`ifdef INTEGER_DIVIDE_SIGNED_EN
                    q_neg    <= dvd_neg ^ dvs_neg;
                    r_neg    <= dvd_neg;
                    ovf_case <= i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);
`endif
                end
                S_RUN: begin
                    quo      <= quo_nxt;
                    rem      <= rem_nxt;
                    step_cnt <= step_cnt + CNT_W'(1);
                end
                S_FIXUP: begin
                    o_quotient    <= div_zero ? '1 : quo_fix;
                    o_remainder   <= rem_fix;
                    o_div_by_zero <= div_zero;
`ifdef INTEGER_DIVIDE_SIGNED_EN
                    res_ovf       <= ovf_case;
                    if (ovf_case) begin
                        o_quotient  <= MIN_NEG;
                        o_remainder <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/integer_divide.md
# integer_divide

Multi-cycle signed/unsigned integer divider with configurable throughput and output backpressure. It is the next-generation replacement for the GPU's single-mode unsigned divider, serving the rasteriser and texture-coordinate paths. It retires `BITS_PER_CYCLE` quotient bits per clock. It reports divide-by-zero and signed overflow, and holds its result until the consumer acknowledges it.

## Interface
- `WIDTH`, default 16: operand and result width in bits; must be ≥ 2.
- `BITS_PER_CYCLE`, default 1: quotient bits resolved per iteration; must divide `WIDTH` exactly. `STEPS = WIDTH / BITS_PER_CYCLE`.

- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  request; accepted only on an edge where `o_ready` is high.
- `i_signed`  in  1  1 means two's-complement operands; sampled with `i_start`.
- `i_dividend`  in  WIDTH  sampled with `i_start`.
- `i_divisor`  in  WIDTH  sampled with `i_start`.
- `i_ack`  in  1  consumer accepts the result; meaningful only while `o_valid` is high.
- `o_ready`  out  1  high in IDLE only.
- `o_valid`  out  1  high in DONE only; remains high until acknowledged.
- `o_quotient`  out  WIDTH  valid while `o_valid` is high.
- `o_remainder`  out  WIDTH  valid while `o_valid` is high.
- `o_div_by_zero`  out  1  valid while `o_valid` is high.
- `o_overflow`  out  1  valid while `o_valid` is high.

## Operation
- **States:** IDLE, RUN, FIXUP, DONE.
- **IDLE → RUN:** on an edge with `i_start` high.
  - Latch the magnitudes of the operands; negate when `i_signed` is high and the MSB is set.
  - Latch the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
  - Clear the step counter.
- **RUN:** each edge performs `BITS_PER_CYCLE` restoring shift-subtract steps on a `(WIDTH+1)`-bit partial remainder. After `STEPS` edges, go to FIXUP.
- **FIXUP (one edge):**
  - Negate quotient and/or remainder according to the latched signs.
  - Apply special cases, then go to DONE.
- **Special cases:**
  - **Divisor == 0:** quotient = all ones, remainder = original dividend, `o_div_by_zero` = 1, regardless of `i_signed`.
  - **Signed overflow** (`i_signed`, dividend = 100…0, divisor = all ones): quotient = 100…0, remainder = 0, `o_overflow` = 1.
- **DONE → IDLE:** on an edge with `i_ack` high. Outputs stay stable until that edge.
- **Rounding:** signed division truncates toward zero; a non-zero remainder takes the dividend's sign. Unsigned results are exact floor division.
- **Ignored inputs:**
  - `i_start` in RUN, FIXUP or DONE: no effect.
  - `i_ack` outside DONE: no effect.
  - Operand changes after the accept edge: no effect.

## Timing
- **Reset (asynchronous, immediate):** state IDLE; `o_ready` = 1; `o_valid`, `o_quotient`, `o_remainder`, `o_div_by_zero`, `o_overflow` = 0.
- **Reset mid-operation:** the operation is abandoned; no `o_valid` pulse follows.
- **Latency:** `o_valid` rises `STEPS + 1` edges after the accept edge. This is fixed and independent of operand values and special cases.
  - `WIDTH` = 16, `BITS_PER_CYCLE` = 1: 17 edges.
  - `WIDTH` = 16, `BITS_PER_CYCLE` = 4: 5 edges.
- **Back-to-back:** with `i_ack` held high, `o_valid` lasts one cycle and `o_ready` returns on the next edge.
  - Minimum issue interval: `STEPS + 3` cycles.
  - `i_start` is not accepted in the cycle where `i_ack` retires DONE.
- **Output timing:** `o_ready` and `o_valid` are decoded directly from the state register, with no combinational path from inputs. Result outputs are registered.

## Configuration
- **`INTEGER_DIVIDE_SIGNED_EN`**
  - Defined: full signed support as described; sign latches, negation logic and `o_overflow` are present.
  - Undefined: `i_signed` is ignored and every operation is unsigned. `o_overflow` is tied to 0, and FIXUP only applies the divide-by-zero result. Latency is unchanged.

## Test plan
- **Unsigned:** 1000 / 7, `i_signed` = 0 → quotient 142, remainder 6, flags 0, `o_valid` exactly 17 edges after accept.
- **Signed:** −7 / 2 (0xFFF9 / 0x0002), `i_signed` = 1 → quotient 0xFFFD, remainder 0xFFFF; 7 / −2 → quotient 0xFFFD, remainder 0x0001.
- **Divide by zero:** 1234 / 0 in both modes → quotient 0xFFFF, remainder 1234 (0x04D2), `o_div_by_zero` = 1, latency still 17.
- **Signed overflow:** 0x8000 / 0xFFFF, `i_signed` = 1 → quotient 0x8000, remainder 0, `o_overflow` = 1. Without `INTEGER_DIVIDE_SIGNED_EN`, the same operands give quotient 0, remainder 0x8000, `o_overflow` = 0.
- **Backpressure:** hold `i_ack` low for 5 cycles → outputs stable, `o_ready` low. Pulse `i_start` with new operands during RUN and DONE → ignored. After `i_ack`, `o_ready` returns one edge later.
- **Reset and throughput:**
  - Assert `i_reset_n` low during RUN → outputs reset immediately, no `o_valid` afterwards.
  - Then run `BITS_PER_CYCLE` = 4: 0xFFFF / 0x0003 → quotient 0x5555, remainder 0, latency 5 edges.
